uart_tx_drain: RTL and testbench
================================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BIT_RATE, default 115200, meaning serial bit rate in bits/s.
REQ-003 The block SHALL have parameter WIDTH, default 8, meaning payload bits per frame, equal to the upstream FIFO data width.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO holds no words.
REQ-007 The block SHALL have port fifo_read, output, 1 bit: single-cycle pop request to the FIFO.
REQ-008 The block SHALL have port fifo_data, input, WIDTH bits: FIFO read word, registered by the FIFO and valid the cycle after the pop.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-011 The block SHALL use CLKS_PER_BIT = CLK_FREQ / BIT_RATE (integer division) clocks per bit, with a counter $clog2(CLKS_PER_BIT) bits wide.
REQ-012 The FSM SHALL have the states IDLE, POP, LOAD, START, DATA, PARITY and STOP.
REQ-013 In IDLE with fifo_empty=0, the block SHALL assert fifo_read for exactly one cycle and enter POP.
REQ-014 POP SHALL be a one-cycle wait; in LOAD the block SHALL capture fifo_data into a shift register and enter START.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL shift WIDTH bits LSB first, each bit held CLKS_PER_BIT cycles.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-018 On leaving STOP, the block SHALL pop again in the same cycle it enters IDLE if fifo_empty=0; otherwise it SHALL remain in IDLE.
REQ-019 fifo_read SHALL never be asserted while fifo_empty=1 or outside IDLE, so there is at most one outstanding pop.
REQ-020 fifo_empty toggling during a frame SHALL NOT affect the frame in progress.
REQ-021 Back-to-back frames SHALL have exactly 3 idle-high cycles (IDLE, POP, LOAD) between the stop bit and the next start bit.
REQ-022 The bit counter SHALL wrap from WIDTH-1 to 0 on exit from DATA.
REQ-023 tx SHALL be registered, with no combinational path from any input to tx.

Reset
REQ-024 While reset=1, the block SHALL set state=IDLE, tx=1, fifo_read=0, busy=0, and clear all counters and the shift register.
REQ-025 Reset asserted mid-frame SHALL abort the frame and return tx to 1 on the next edge, with no further pop until reset deasserts.

Configuration
REQ-026 The block SHALL support the macro UART_TX_PARITY_EN.
REQ-027 With UART_TX_PARITY_EN defined, DATA SHALL be followed by PARITY, driving the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles before STOP.
REQ-028 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-029 The shared package uart_pkg SHALL hold the FSM state encoding and a constant function computing CLKS_PER_BIT.
REQ-030 The sub-module uart_baud_gen SHALL produce a one-cycle bit tick, restartable by a load pulse in LOAD.

Verification (CLK_FREQ=100, BIT_RATE=10, i.e. 10 clocks per bit, WIDTH=8)
REQ-031 After reset with fifo_empty=1, the bench SHALL see tx=1, busy=0 and fifo_read=0 for 200 cycles.
REQ-032 With 0xA5 queued, the bench SHALL see one fifo_read pulse and tx = 0,1,0,1,0,0,1,0,1,1 with each bit 10 cycles wide, then busy=0.
REQ-033 With 0x00 and 0xFF queued, the bench SHALL see exactly two pops, two frames and 3 idle-high cycles between the first stop bit and the second start bit.
REQ-034 With reset pulsed at cycle 45 of a 0x3C frame, the bench SHALL see tx=1 the next cycle, busy=0, and no pop while reset=1.
REQ-035 With UART_TX_PARITY_EN defined and 0x07 sent, the bench SHALL see the parity bit=1 between data bit 7 and the stop bit, for a frame length of 110 cycles.
REQ-036 With fifo_empty forced to 1 mid-frame, the bench SHALL see the current frame complete unchanged and no further fifo_read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit drain: FSM encoding and bit-timing helpers.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPop    = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StStart  = 3'd3;
    localparam logic [2:0] StData   = 3'd4;
    localparam logic [2:0] StStop   = 3'd5;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd6;
`endif

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned bit_rate);
        return clk_freq / bit_rate;
    endfunction

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses tick for one cycle every CLKS_PER_BIT clocks.
// A load pulse restarts the period so the first bit of a frame is full length.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (load || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains an upstream FIFO one word per frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned BIT_RATE = 115200,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_read,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             tx,
    output logic             busy
);

    localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int unsigned BitW = cnt_width(WIDTH);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             baud_load;
    logic             bit_tick;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(ClksPerBit)
    ) u_baud_gen (
        .clk  (clk),
        .reset(reset),
        .load (baud_load),
        .tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_load = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = StPop;
            end
            // FIFO registers its output, so the popped word is stable from here on.
            StPop: state_d = StLoad;
            StLoad: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
                baud_load = 1'b1;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^fifo_data;
`endif
                state_d   = StStart;
            end
            StStart: begin
                if (bit_tick) state_d = StData;
            end
            StData: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the next state so tx is a plain register output.
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign fifo_read = (state_q == StIdle) && !fifo_empty && !reset;
    assign busy      = (state_q != StIdle);
    assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain at 10 clocks per bit with a FIFO model and frame scoreboard.
// Frames include a parity bit when built with UART_TX_PARITY_EN.
module tb_uart_tx_drain;

    localparam int unsigned CLK_FREQ = 100;
    localparam int unsigned BIT_RATE = 10;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CPB      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 3;
`else
    localparam int unsigned NBITS = WIDTH + 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             fifo_empty;
    logic             fifo_read;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             tx;
    logic             busy;
    logic             force_empty = 1'b0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int n_push = 0;
    int n_pop = 0;
    int n_bad_pop = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (n_push == n_pop);

    uart_tx_drain #(
        .CLK_FREQ(CLK_FREQ),
        .BIT_RATE(BIT_RATE),
        .WIDTH   (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .fifo_data (fifo_data),
        .tx        (tx),
        .busy      (busy)
    );

    // Registered-output FIFO model; also flags any pop that should never happen.
    always @(posedge clk) begin
        if (fifo_read === 1'b1) begin
            if (fifo_empty || busy || reset) n_bad_pop <= n_bad_pop + 1;
            if (fifo_q.size() > 0) begin
                fifo_data <= fifo_q[0];
                void'(fifo_q.pop_front());
            end
            n_pop <= n_pop + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        n_push++;
    endtask

    task automatic wait_start(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " start seen"}, 32'(ok), 32'd1);
    endtask

    // Checks one frame bit by bit; returns at the negedge of the last stop-bit cycle.
    task automatic check_frame(input string tag, input bit started);
        logic [WIDTH-1:0] d;
        logic             bits[NBITS];
        logic             obs;
        bit               ok;
        check({tag, " scoreboard"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        d = exp_q.pop_front();
        bits[0] = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) bits[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
        bits[WIDTH+1] = ^d;
`endif
        bits[NBITS-1] = 1'b1;
        ok = started;
        if (!started) wait_start(tag, ok);
        if (!ok) return;
        for (int b = 0; b < int'(NBITS); b++) begin
            obs = bits[b];
            for (int k = 0; k < int'(CPB); k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                if (tx !== bits[b]) obs = tx;
            end
            check($sformatf("%s bit%0d", tag, b), 32'(obs), 32'(bits[b]));
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx === 1'b0) break;
            n++;
        end
    endtask

    initial begin
        int  bad_tx, bad_busy, bad_rd, gap, pops;
        bit  ok;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle with an empty FIFO.
        bad_tx = 0; bad_busy = 0; bad_rd = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (fifo_read !== 1'b0) bad_rd++;
        end
        check("idle tx low cycles", 32'(bad_tx), 0);
        check("idle busy cycles", 32'(bad_busy), 0);
        check("idle fifo_read cycles", 32'(bad_rd), 0);
        check("idle pops", 32'(n_pop), 0);

        // Single frame 0xA5.
        push(8'hA5);
        check_frame("A5", 1'b0);
        @(negedge clk);
        check("A5 busy after", 32'(busy), 0);
        check("A5 tx after", 32'(tx), 1);
        check("A5 pops", 32'(n_pop), 1);

        // Back-to-back 0x00, 0xFF.
        push(8'h00);
        push(8'hFF);
        check_frame("00", 1'b0);
        count_high(gap);
        check("b2b idle gap", 32'(gap), 3);
        check_frame("FF", 1'b1);
        @(negedge clk);
        check("b2b busy after", 32'(busy), 0);
        check("b2b pops", 32'(n_pop), 3);

        // Reset at cycle 45 of a 0x3C frame.
        push(8'h3C);
        wait_start("3C", ok);
        repeat (45) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_front());
        push(8'h55);
        pops = n_pop;
        @(negedge clk);
        check("abort tx", 32'(tx), 1);
        check("abort busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        check("pops during reset", 32'(n_pop), 32'(pops));
        check("reset tx hold", 32'(tx), 1);
        reset = 1'b0;
        check_frame("55 after reset", 1'b0);
        @(negedge clk);
        check("reset pops", 32'(n_pop), 5);

        // 0x07: parity bit is 1 when enabled.
        push(8'h07);
        check_frame("07", 1'b0);
        @(negedge clk);
        check("07 busy after", 32'(busy), 0);

        // FIFO forced empty mid-frame.
        push(8'h5A);
        push(8'h81);
        fork
            check_frame("5A forced", 1'b0);
            begin
                repeat (40) @(negedge clk);
                force_empty = 1'b1;
            end
        join
        pops = n_pop;
        repeat (50) @(negedge clk);
        check("forced pops", 32'(pops), 7);
        check("forced no pop", 32'(n_pop), 7);
        check("forced busy", 32'(busy), 0);
        check("forced tx", 32'(tx), 1);
        force_empty = 1'b0;
        check_frame("81 released", 1'b0);
        @(negedge clk);
        check("final pops", 32'(n_pop), 8);
        check("illegal pops", 32'(n_bad_pop), 0);
        check("scoreboard drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
